ram8_fifo_ctrl: RTL and testbench
=================================

Name: ram8_fifo_ctrl

Overview:
- Upstream controller for the 8x16 register-file RAM (`ram8`); it turns that RAM into an 8-deep, 16-bit synchronous FIFO.
- It owns the write/read pointers, occupancy count, full/empty flags and push/pop handshakes.
- It drives the RAM's address, write, read, enable and data-in pins, and registers the RAM's combinational read data for downstream logic.
- Only one RAM operation per cycle, because the RAM has a single shared address port.

Parameters:
- DATA_W, 16, FIFO/RAM word width; must match RAM data width.
- ADDR_W, 3, RAM address width; depth = 2**ADDR_W = 8.

Ports:
- clk  input  1  system clock, rising edge; same clock as the RAM.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; empties the FIFO, RAM contents untouched.
- push_valid  input  1  producer has a word on push_data.
- push_ready  output  1  controller accepts a push this cycle.
- push_data  input  DATA_W  word to enqueue.
- pop_req  input  1  consumer requests one word.
- pop_ready  output  1  controller accepts a pop this cycle.
- pop_valid  output  1  pop_data holds a dequeued word (1-cycle pulse).
- pop_data  output  DATA_W  registered dequeued word.
- count  output  ADDR_W+1  current occupancy, 0..8.
- full  output  1  count == 8.
- empty  output  1  count == 0.
- ram_add  output  ADDR_W  RAM address.
- ram_w  output  1  RAM write strobe.
- ram_r  output  1  RAM read strobe.
- ram_en  output  1  RAM decoder enable.
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM combinational read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset state: wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, pop_data=0. Outputs follow: empty=1, full=0.
- RAM controls during reset: while rst_n=0, ram_w, ram_r and ram_en are forced 0.
- Handshakes:
  - pop_ready = rst_n & !clr & !empty.
  - push_ready = rst_n & !clr & !full & !(pop_req & pop_ready). Pop has priority; a simultaneous push stalls and the producer holds push_valid/push_data.
- Push accepted (push_valid & push_ready), combinational in that cycle:
  - ram_add=wr_ptr, ram_w=1, ram_r=0, ram_en=1, ram_din=push_data.
  - The RAM stores the word at the clk edge.
  - wr_ptr increments mod 8; count increments.
- Pop accepted (pop_req & pop_ready), combinational in that cycle:
  - ram_add=rd_ptr, ram_r=1, ram_w=0, ram_en=1.
  - At the clk edge, pop_data<=ram_dout and pop_valid<=1.
  - rd_ptr increments mod 8; count decrements.
- Pop latency: accepted in cycle N gives pop_valid=1 in cycle N+1 only. pop_data holds its value until the next pop.
- Idle: ram_en=0, ram_w=0, ram_r=0, ram_add=rd_ptr, ram_din=push_data.
- Read-after-write: a word pushed in cycle N is poppable from cycle N+1.
- Wrap-around: pointers are ADDR_W bits and wrap 7->0 naturally. Full/empty come from count, not from pointer compare.
- Push while full or pop while empty: ignored (ready=0). No state change; pop_valid stays 0.
- clr=1:
  - No RAM access this cycle.
  - At the edge: wr_ptr=rd_ptr=0, count=0, pop_valid=0. pop_data is retained.
  - clr overrides any push/pop asserted in the same cycle.
- Reset mid-operation: an in-flight write is aborted, because ram_w drops combinationally. RAM contents are undefined to the FIFO; the FIFO is empty afterwards.

Optional Feature:
- Macro: RAM8_FIFO_ERR_FLAG_EN.
- When defined:
  - Adds outputs ovf and udf, each 1 bit, both sticky.
  - ovf sets on push_valid while full; udf sets on pop_req while empty.
  - Both clear on rst_n=0 or clr=1.
  - They have no effect on the datapath.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ram8_fifo_pkg: DATA_W and ADDR_W defaults, DEPTH = 2**ADDR_W, an op enum (OP_IDLE, OP_PUSH, OP_POP, OP_CLR) and the count type of width ADDR_W+1.
- Sub-module wrap_ptr: ADDR_W-bit pointer with async reset, synchronous clear and increment-enable. It is instantiated twice, for wr_ptr and rd_ptr.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release -> empty=1, full=0, count=0, pop_valid=0, ram_en=0 throughout reset.
- Push 16'hA000..16'hA007 on consecutive cycles -> count reaches 8, full=1, push_ready=0. A 9th push of 16'hBEEF is ignored and count stays 8.
- From full, pop 8 times -> pop_data equals 16'hA000..16'hA007 in order, each one cycle after acceptance. Afterwards empty=1.
- Push 5, pop 5, then push 6 more (wrap) -> wr_ptr passes 7->0 and the pops return the 6 words in order. ram_add goes 5,6,7,0,1,2.
- push_valid=1 and pop_req=1 with count=3 -> pop serviced (ram_r=1, ram_add=rd_ptr), push_ready=0, count=2. The next cycle the held push completes and count=3.
- clr pulse with count=4 and push_valid=1 -> next cycle count=0, empty=1, and no ram_w during the clr cycle. With RAM8_FIFO_ERR_FLAG_EN defined, pop_req on empty sets udf=1 until clr.

Source files
------------

// File: rtl/ram8_fifo_pkg.sv
// ram8_fifo_pkg: shared widths, operation encoding and count type for the ram8 FIFO controller.
`default_nettype none

package ram8_fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  // One RAM operation per cycle; OP_CLR means a flush with no RAM access.
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  typedef logic [DEF_ADDR_W:0] count_t;

endpackage

`default_nettype wire

// File: rtl/ram8_fifo_ctrl_wrap_ptr.sv
// wrap_ptr: ADDR_W-bit circular pointer with async active-low reset, sync clear and increment enable.
`default_nettype none

module wrap_ptr #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram8_fifo_ctrl.sv
// ram8_fifo_ctrl: drives the single-port 8x16 ram8 as an 8-deep synchronous FIFO.
// Optional sticky ovf/udf error outputs are built when RAM8_FIFO_ERR_FLAG_EN is defined.
`default_nettype none

module ram8_fifo_ctrl
  import ram8_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_req,
  output logic              pop_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] ram_add,
  output logic              ram_w,
  output logic              ram_r,
  output logic              ram_en,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef RAM8_FIFO_ERR_FLAG_EN
  ,
  output logic              ovf,
  output logic              udf
`endif
);

  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_fire;
  logic              pop_fire;
  logic              flush;
  op_e               op;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Pop wins the shared address port; a colliding push is stalled, not dropped.
  assign pop_ready  = rst_n & ~clr & ~empty;
  assign push_ready = rst_n & ~clr & ~full & ~(pop_req & pop_ready);
  assign pop_fire   = pop_req & pop_ready;
  assign push_fire  = push_valid & push_ready;
  assign flush      = rst_n & clr;

  always_comb begin
    op = OP_IDLE;
    if (flush)          op = OP_CLR;
    else if (pop_fire)  op = OP_POP;
    else if (push_fire) op = OP_PUSH;
  end

  always_comb begin
    ram_en  = 1'b0;
    ram_w   = 1'b0;
    ram_r   = 1'b0;
    ram_add = rd_ptr;
    ram_din = push_data;
    case (op)
      OP_PUSH: begin
        ram_add = wr_ptr;
        ram_w   = 1'b1;
        ram_en  = 1'b1;
      end
      OP_POP: begin
        ram_r  = 1'b1;
        ram_en = 1'b1;
      end
      default: ;
    endcase
  end

  wrap_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (push_fire),
    .ptr   (wr_ptr)
  );

  wrap_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (pop_fire),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (push_fire) begin
      count <= count + CNT_ONE;
    end else if (pop_fire) begin
      count <= count - CNT_ONE;
    end
  end

  // pop_data is deliberately kept across a flush; only pop_valid is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else begin
      pop_valid <= pop_fire;
      if (pop_fire) pop_data <= ram_dout;
    end
  end

`ifdef RAM8_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push_valid & full) ovf <= 1'b1;
      if (pop_req & empty)   udf <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram8_fifo_ctrl.sv
// tb_ram8_fifo_ctrl: directed stimulus with a behavioural ram8 and a scoreboard queue of expected pop words.
`default_nettype none

module tb_ram8_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        push_valid;
  logic        push_ready;
  logic [15:0] push_data;
  logic        pop_req;
  logic        pop_ready;
  logic        pop_valid;
  logic [15:0] pop_data;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic [2:0]  ram_add;
  logic        ram_w;
  logic        ram_r;
  logic        ram_en;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
`ifdef RAM8_FIFO_ERR_FLAG_EN
  logic        ovf;
  logic        udf;
`endif

  ram8_fifo_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_req    (pop_req),
    .pop_ready  (pop_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ram_add    (ram_add),
    .ram_w      (ram_w),
    .ram_r      (ram_r),
    .ram_en     (ram_en),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
`ifdef RAM8_FIFO_ERR_FLAG_EN
    ,
    .ovf        (ovf),
    .udf        (udf)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ram8: synchronous write, combinational read.
  logic [15:0] mem [8];
  assign ram_dout = mem[ram_add];
  always @(posedge clk) if (ram_en && ram_w) mem[ram_add] <= ram_din;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] sb [$];
  int          m_count  = 0;
  logic [2:0]  m_wr     = 3'd0;
  logic [2:0]  m_rd     = 3'd0;
  logic        m_pend   = 1'b0;
  logic [15:0] m_last   = 16'h0;
  logic        m_ovf    = 1'b0;
  logic        m_udf    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic pv, input logic [15:0] pd, input logic pr, input logic cl);
    logic e_pop_rdy, e_pop_fire, e_push_rdy, e_push_fire;
    push_valid = pv;
    push_data  = pd;
    pop_req    = pr;
    clr        = cl;
    #1;
    e_pop_rdy   = !cl && (m_count != 0);
    e_pop_fire  = pr && e_pop_rdy;
    e_push_rdy  = !cl && (m_count != 8) && !e_pop_fire;
    e_push_fire = pv && e_push_rdy;
    chk("pop_ready",  32'(pop_ready),  32'(e_pop_rdy));
    chk("push_ready", 32'(push_ready), 32'(e_push_rdy));
    chk("ram_en", 32'(ram_en), 32'(e_pop_fire || e_push_fire));
    chk("ram_w",  32'(ram_w),  32'(e_push_fire));
    chk("ram_r",  32'(ram_r),  32'(e_pop_fire));
    chk("ram_add", 32'(ram_add), 32'(e_push_fire ? m_wr : m_rd));
    if (e_push_fire) chk("ram_din", 32'(ram_din), 32'(pd));
    @(posedge clk);
    if (cl) begin
      m_count = 0; m_wr = 3'd0; m_rd = 3'd0; m_pend = 1'b0;
      m_ovf = 1'b0; m_udf = 1'b0;
      sb.delete();
    end else begin
      if (pv && m_count == 8) m_ovf = 1'b1;
      if (pr && m_count == 0) m_udf = 1'b1;
      m_pend = e_pop_fire;
      if (e_pop_fire) begin
        m_last = sb.pop_front();
        m_rd++;
        m_count--;
      end
      if (e_push_fire) begin
        sb.push_back(pd);
        m_wr++;
        m_count++;
      end
    end
    #1;
    chk("count", 32'(count), 32'(m_count));
    chk("empty", 32'(empty), 32'(m_count == 0));
    chk("full",  32'(full),  32'(m_count == 8));
    chk("pop_valid", 32'(pop_valid), 32'(m_pend));
    chk("pop_data",  32'(pop_data),  32'(m_last));
`ifdef RAM8_FIFO_ERR_FLAG_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
`endif
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    rst_n      = 1'b0;
    clr        = 1'b0;
    push_valid = 1'b1;
    push_data  = 16'h1234;
    pop_req    = 1'b1;

    // Reset held two cycles with requests active: RAM strobes must stay low.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_ram_w",  32'(ram_w),  32'd0);
      chk("rst_ram_r",  32'(ram_r),  32'd0);
      chk("rst_count",  32'(count),  32'd0);
      chk("rst_empty",  32'(empty),  32'd1);
      chk("rst_full",   32'(full),   32'd0);
      chk("rst_pop_valid",  32'(pop_valid),  32'd0);
      chk("rst_push_ready", 32'(push_ready), 32'd0);
      chk("rst_pop_ready",  32'(pop_ready),  32'd0);
    end
    push_valid = 1'b0;
    pop_req    = 1'b0;
    rst_n      = 1'b1;

    // Fill, then an ignored ninth push.
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);

    // Drain in order.
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);

    // Push 5, pop 5, push 6 across the 7->0 wrap, pop them back.
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'hB000 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // count=3: simultaneous push/pop, pop wins, held push completes next cycle.
    cycle(1'b1, 16'hD000, 1'b1, 1'b0);
    cycle(1'b1, 16'hD000, 1'b0, 1'b0);
    cycle(1'b1, 16'hD001, 1'b0, 1'b0);

    // Flush at count=4 with a push pending; then pointers restart at 0.
    cycle(1'b1, 16'hE000, 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    cycle(1'b1, 16'hF000, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
